// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and helpers for the bit-serial arithmetic units
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Signed overflow of a - b: operand signs differ and the result sign left the minuend's.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake bundle for the serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/fullsubtractor.sv
// rtl/fullsubtractor.sv - single-bit full subtractor cell
module fullsubtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial a - b with start/busy/done handshake
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  sub
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             br_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] a_d;

    fullsubtractor u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (d_bit),
        .bout_o (br_d)
    );

    // The minuend register doubles as the result register: each difference bit
    // enters at the MSB as the consumed operand bit leaves at the LSB.
    assign a_d = {d_bit, a_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (sub.start) begin
                        a_q     <= sub.a;
                        b_q     <= sub.b;
                        a_msb_q <= sub.a[WIDTH-1];
                        b_msb_q <= sub.b[WIDTH-1];
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_q   <= a_d;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        diff_q  <= a_d;
                        bout_q  <= br_d;
                        ovf_q   <= sub_ovf(a_msb_q, b_msb_q, d_bit);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sub.busy = busy_q;
    assign sub.done = done_q;
    assign sub.diff = diff_q;
    assign sub.bout = bout_q;
    assign sub.ovf  = ovf_q;

endmodule
